// File: rtl/wr_packer_pkg.sv
// Shared definitions for the write-burst packer: FSM state encoding,
// beat/page geometry and the default maximum burst length.
package wr_packer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_DATA   = 3'd2,
        ST_WAIT_B = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int BEAT_BYTES        = 64;
    localparam int PAGE_BYTES        = 4096;
    localparam int DEFAULT_MAX_BURST = 64;

endpackage

// File: rtl/wr_beat_fifo.sv
// Synchronous beat buffer holding data plus byte strobes, with an exact
// occupancy count. Push is ignored when full, pop is ignored when empty;
// a simultaneous push and pop leaves the count unchanged.
module wr_beat_fifo #(
    parameter int DATA_W = 512,
    parameter int STRB_W = 64,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic [STRB_W-1:0]        push_strobe,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic [STRB_W-1:0]        pop_strobe,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [STRB_W-1:0] strb_mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full       = (count == (AW + 1)'(DEPTH));
    assign empty      = (count == '0);
    assign push_ok    = push && !full;
    assign pop_ok     = pop && !empty;
    assign pop_data   = data_mem[rd_ptr];
    assign pop_strobe = strb_mem[rd_ptr];

    // Storage array: payload only, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            data_mem[wr_ptr] <= push_data;
            strb_mem[wr_ptr] <= push_strobe;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of 2)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wr_burst_packer.sv
// Write-burst packer: buffers decompressed beats and emits them to host
// memory as a sequence of bursts, one outstanding at a time.
// Optional feature macro: WR_PACKER_4K_SPLIT_EN -- when defined, no burst
// is allowed to cross a 4 KB page boundary.
module wr_burst_packer
    import wr_packer_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int FIFO_DEPTH         = 64,
    parameter int MAX_BURST          = DEFAULT_MAX_BURST
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   des_addr,
    input  logic [31:0]                     decompression_length,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   in_data,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] in_strobe,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            wr_req,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   wr_addr,
    output logic [7:0]                      wr_len,
    input  logic                            wr_req_ack,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   wr_data,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] wr_strobe,
    output logic                            wr_wvalid,
    output logic                            wr_wlast,
    input  logic                            wr_ready,
    output logic                            bready,
    input  logic                            bresp,
    output logic                            busy,
    output logic                            done
);

    state_t                          state;
    state_t                          state_nxt;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_r;
    logic [31:0]                     remaining_r;
    logic [31:0]                     total_r;
    logic [31:0]                     accepted_r;
    logic [8:0]                      beat_cnt_r;
    logic [31:0]                     total_beats_in;
    logic [31:0]                     lim;
    logic [8:0]                      blen;
    logic [8:0]                      blen_m1;
    logic                            start_ok;
    logic                            push;
    logic                            pop;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]     fifo_count;

    // Beats needed for the job, rounded up to whole 64-byte beats
    assign total_beats_in = 32'(({1'b0, decompression_length} + 33'd63) >> 6);
    assign start_ok       = start && (state == ST_IDLE || state == ST_DONE);
    assign push           = in_valid && in_ready;
    assign pop            = wr_wvalid && wr_ready;

    // Length of the next burst from the remaining beats and the active limits
    always_comb begin
`ifdef WR_PACKER_4K_SPLIT_EN
        logic [31:0] page_beats;
`endif
        lim = remaining_r;
        if (lim > 32'(MAX_BURST)) lim = 32'(MAX_BURST);
`ifdef WR_PACKER_4K_SPLIT_EN
        page_beats = (32'(PAGE_BYTES) - {20'd0, addr_r[11:0]}) / 32'(BEAT_BYTES);
        if (lim > page_beats) lim = page_beats;
`endif
        blen    = lim[8:0];
        blen_m1 = blen - 9'd1;
    end

    // wr_addr/wr_len derive from registers that only move between bursts
    assign wr_addr = addr_r;
    assign wr_len  = (remaining_r == '0) ? 8'd0 : blen_m1[7:0];

    wr_beat_fifo #(
        .DATA_W (C_M_AXI_DATA_WIDTH),
        .STRB_W (C_M_AXI_DATA_WIDTH / 8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_data   (in_data),
        .push_strobe (in_strobe),
        .pop         (pop),
        .pop_data    (wr_data),
        .pop_strobe  (wr_strobe),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = (total_beats_in == '0) ? ST_DONE : ST_REQ;
            ST_REQ:           if (wr_req && wr_req_ack) state_nxt = ST_DATA;
            ST_DATA:          if (pop && wr_wlast) state_nxt = ST_WAIT_B;
            ST_WAIT_B:        if (bresp) state_nxt = (remaining_r == 32'(blen)) ? ST_DONE : ST_REQ;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs; a burst is requested only once all its beats are buffered
    always_comb begin
        busy      = (state == ST_REQ) || (state == ST_DATA) || (state == ST_WAIT_B);
        done      = (state == ST_DONE);
        wr_req    = (state == ST_REQ) && (32'(fifo_count) >= 32'(blen));
        wr_wvalid = (state == ST_DATA) && !fifo_empty;
        wr_wlast  = wr_wvalid && (beat_cnt_r == blen_m1);
        bready    = (state == ST_WAIT_B);
        in_ready  = busy && !fifo_full && (accepted_r != total_r);
    end

    // Job bookkeeping: address, remaining/accepted beats, beat index within burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r      <= '0;
            remaining_r <= '0;
            total_r     <= '0;
            accepted_r  <= '0;
            beat_cnt_r  <= '0;
        end else begin
            if (start_ok) begin
                addr_r      <= des_addr;
                remaining_r <= total_beats_in;
                total_r     <= total_beats_in;
                accepted_r  <= '0;
                beat_cnt_r  <= '0;
            end else begin
                if (push) accepted_r <= accepted_r + 32'd1;
                if (pop)  beat_cnt_r <= wr_wlast ? 9'd0 : beat_cnt_r + 9'd1;
                if (state == ST_WAIT_B && bresp) begin
                    addr_r      <= addr_r + C_M_AXI_ADDR_WIDTH'({blen, 6'b0});
                    remaining_r <= remaining_r - 32'(blen);
                end
            end
        end
    end

endmodule

// File: tb/tb_wr_burst_packer.sv
// Bench for wr_burst_packer: randomized handshakes on every interface,
// checked cycle by cycle against a job-level reference model.
module tb_wr_burst_packer;

    localparam int AW    = 64;
    localparam int DW    = 512;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 64;
    localparam int MAXB  = 64;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] des_addr;
    logic [31:0]   decompression_length;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_strobe;
    logic          in_valid;
    logic          in_ready;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_len;
    logic          wr_req_ack;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strobe;
    logic          wr_wvalid;
    logic          wr_wlast;
    logic          wr_ready;
    logic          bready;
    logic          bresp;
    logic          busy;
    logic          done;

    wr_burst_packer #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .FIFO_DEPTH         (DEPTH),
        .MAX_BURST          (MAXB)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .des_addr             (des_addr),
        .decompression_length (decompression_length),
        .in_data              (in_data),
        .in_strobe            (in_strobe),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .wr_req               (wr_req),
        .wr_addr              (wr_addr),
        .wr_len               (wr_len),
        .wr_req_ack           (wr_req_ack),
        .wr_data              (wr_data),
        .wr_strobe            (wr_strobe),
        .wr_wvalid            (wr_wvalid),
        .wr_wlast             (wr_wlast),
        .wr_ready             (wr_ready),
        .bready               (bready),
        .bresp                (bresp),
        .busy                 (busy),
        .done                 (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model of the job in flight
    logic [DW-1:0] beat_data [$];
    logic [SW-1:0] beat_strb [$];
    logic [AW-1:0] req_addr  [$];
    int            req_len   [$];
    int            total, pushed, popped, req_idx, beat_in_burst;
    int            phase;          // 0 none, 1 awaiting request, 2 data, 3 awaiting response
    bit            exp_busy, exp_done;
    bit            e_rdy, e_req, e_wv, e_last;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Expected bursts: repeatedly take the largest legal chunk of what remains
    task automatic plan(input logic [AW-1:0] addr, input int unsigned len);
        longint unsigned a;
        int rem, b;
        int pg;
        total = int'((longint'(len) + 63) / 64);
        beat_data.delete(); beat_strb.delete(); req_addr.delete(); req_len.delete();
        a   = addr;
        rem = total;
        while (rem > 0) begin
            b = (rem > MAXB) ? MAXB : rem;
            pg = 64;
`ifdef WR_PACKER_4K_SPLIT_EN
            pg = (4096 - int'(a % 4096)) / 64;
`endif
            if (b > pg) b = pg;
            req_addr.push_back(a);
            req_len.push_back(b);
            a   += 64 * b;
            rem -= b;
        end
        for (int i = 0; i < total; i++) begin
            logic [SW-1:0] s;
            beat_data.push_back(rand_word());
            s = {$urandom, $urandom};
            if (i == total - 1 && (len % 64) != 0) s = (64'd1 << (len % 64)) - 64'd1;
            beat_strb.push_back(s);
        end
        pushed = 0; popped = 0; req_idx = 0; beat_in_burst = 0;
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, "_wr_req"},    wr_req,    0);
        check({where, "_wr_wvalid"}, wr_wvalid, 0);
        check({where, "_wr_wlast"},  wr_wlast,  0);
        check({where, "_bready"},    bready,    0);
        check({where, "_busy"},      busy,      0);
        check({where, "_done"},      done,      0);
        check({where, "_in_ready"},  in_ready,  0);
        check({where, "_wr_addr"},   wr_addr,   0);
        check({where, "_wr_len"},    wr_len,    0);
    endtask

    // Compare every output against the model, then note what fires at the next edge
    task automatic check_cycle();
        int occ;
        occ    = pushed - popped;
        e_rdy  = exp_busy && (occ < DEPTH) && (pushed < total);
        e_req  = (phase == 1) && (occ >= req_len[req_idx]);
        e_wv   = (phase == 2) && (occ > 0);
        e_last = e_wv && (beat_in_burst == req_len[req_idx] - 1);
        check("busy",      busy,      exp_busy);
        check("done",      done,      exp_done);
        check("in_ready",  in_ready,  e_rdy);
        check("wr_req",    wr_req,    e_req);
        check("wr_wvalid", wr_wvalid, e_wv);
        check("wr_wlast",  wr_wlast,  e_last);
        check("bready",    bready,    phase == 3);
        if (e_req) begin
            check("wr_addr", wr_addr, req_addr[req_idx]);
            check("wr_len",  wr_len,  req_len[req_idx] - 1);
        end
        if (e_wv && popped < total) begin
            check("wr_data",   wr_data,   beat_data[popped]);
            check("wr_strobe", wr_strobe, beat_strb[popped]);
        end
    endtask

    task automatic advance();
        if (in_valid && e_rdy) pushed++;
        if (phase == 1 && e_req && wr_req_ack) begin
            phase = 2;
            beat_in_burst = 0;
        end else if (phase == 2 && e_wv && wr_ready) begin
            popped++;
            if (e_last) begin
                phase = 3;
                beat_in_burst = 0;
            end else begin
                beat_in_burst++;
            end
        end else if (phase == 3 && bresp) begin
            req_idx++;
            if (req_idx == req_len.size()) begin
                phase = 0; exp_busy = 0; exp_done = 1;
            end else begin
                phase = 1;
            end
        end
    endtask

    task automatic drive(input int vprob, input int rprob, input bit toggle, input int cyc);
        in_valid = ($urandom_range(99) < vprob);
        if (pushed < total) begin
            in_data   = beat_data[pushed];
            in_strobe = beat_strb[pushed];
        end else begin
            in_data   = rand_word();
            in_strobe = {$urandom, $urandom};
        end
        wr_ready   = toggle ? cyc[0] : ($urandom_range(99) < rprob);
        wr_req_ack = 1'($urandom_range(1));
        bresp      = 1'($urandom_range(1));
        // A start pulse in the middle of a job must have no effect
        start = exp_busy && (cyc == 10);
        if (start) begin
            des_addr             = {$urandom, $urandom};
            decompression_length = $urandom_range(64 * 300);
        end
    endtask

    task automatic run_job(input logic [AW-1:0] addr, input int unsigned len, input int vprob,
                           input int rprob, input bit toggle, input int abort_pops);
        int cyc;
        bit aborted;
        plan(addr, len);
        @(posedge clk); #1;
        drive(vprob, rprob, toggle, 0);
        start = 1'b1;
        des_addr = addr;
        decompression_length = len;
        @(negedge clk);
        check_cycle();
        advance();
        exp_done = (total == 0);
        exp_busy = (total > 0);
        phase    = (total > 0) ? 1 : 0;
        aborted  = 0;
        cyc      = 1;
        while (cyc < 20000) begin
            @(posedge clk); #1;
            drive(vprob, rprob, toggle, cyc);
            @(negedge clk);
            check_cycle();
            if (exp_done) break;
            advance();
            if (abort_pops > 0 && phase == 2 && popped >= abort_pops) begin
                aborted = 1;
                break;
            end
            cyc++;
        end
        start = 1'b0;
        if (!aborted) begin
            check("job_timeout",   exp_done, 1);
            check("job_pushed",    pushed,   total);
            check("job_popped",    popped,   total);
            check("job_requests",  req_idx,  req_len.size());
        end
    endtask

    initial begin
        rst = 1'b1; start = 0; des_addr = 0; decompression_length = 0;
        in_data = 0; in_strobe = 0; in_valid = 0; wr_req_ack = 0; wr_ready = 0; bresp = 0;
        total = 0; pushed = 0; popped = 0; req_idx = 0; beat_in_burst = 0;
        phase = 0; exp_busy = 0; exp_done = 0;
        req_len.push_back(1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Zero-length job: done without any request
        run_job(64'h800, 0, 50, 50, 0, 0);
        // Two full bursts of 64 beats
        run_job(64'h1000, 8192, 70, 70, 0, 0);
        // Page-straddling job (split or not depending on build)
        run_job(64'h1F80, 256, 60, 60, 0, 0);
        // Partial final beat
        run_job(64'h4_2000, 100, 50, 50, 0, 0);
        // Continuous input, write side ready every other cycle
        run_job(64'h4_0000, 8192, 100, 0, 1, 0);
        // Zero-length restart from DONE
        run_job(64'h0, 0, 50, 50, 0, 0);
        // Random jobs
        for (int j = 0; j < 4; j++) begin
            logic [AW-1:0] ra;
            ra = {$urandom, $urandom};
            ra[5:0] = 6'd0;
            run_job(ra, $urandom_range(1, 64 * 130), $urandom_range(30, 100),
                    $urandom_range(30, 100), 0, 0);
        end

        // Reset in the middle of a data phase, then a fresh job
        run_job(64'h3000, 64 * 40, 80, 30, 0, 3);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst_async");
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        phase = 0; exp_busy = 0; exp_done = 0; total = 0; pushed = 0; popped = 0;
        @(negedge clk);
        check_reset_outputs("post_rst");
        run_job(64'h5000, 64 * 70, 70, 70, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wr_burst_packer.md
WR_BURST_PACKER -- requirements
Module: wr_burst_packer

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 64, host byte-address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 512, beat width; BEAT_BYTES = 64.
REQ-003 SHALL have parameter FIFO_DEPTH, default 64, beat-buffer depth (power of 2, >= MAX_BURST).
REQ-004 SHALL have parameter MAX_BURST, default 64, maximum beats per write request (<= 256).
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 start  in  1  one-cycle pulse; latches des_addr and decompression_length.
REQ-009 des_addr  in  C_M_AXI_ADDR_WIDTH  destination byte address, 64-byte aligned.
REQ-010 decompression_length  in  32  output bytes for the job.
REQ-011 in_data / in_strobe / in_valid  in  512 / 64 / 1  decompressed beat from decompressor.
REQ-012 in_ready  out  1  beat accepted when in_valid & in_ready.
REQ-013 wr_req / wr_addr / wr_len  out  1 / C_M_AXI_ADDR_WIDTH / 8  burst request; wr_len = beats-1.
REQ-014 wr_req_ack  in  1  request accepted.
REQ-015 wr_data / wr_strobe / wr_wvalid / wr_wlast  out  512 / 64 / 1 / 1  write beat.
REQ-016 wr_ready  in  1  beat taken when wr_wvalid & wr_ready.
REQ-017 bready  out  1;  bresp  in  1  write response for current burst.
REQ-018 busy  out  1;  done  out  1  job complete, held until next start.

Function
REQ-019 SHALL compute total_beats = ceil(decompression_length/64) at start.
REQ-020 SHALL buffer input beats in a FIFO; in_ready = !fifo_full; beat with strobe passes unmodified.
REQ-021 SHALL use states IDLE, REQ, DATA, WAIT_B, DONE.
REQ-022 IDLE->REQ on start if total_beats>0; IDLE->DONE on start if total_beats==0 (no requests issued).
REQ-023 burst_len = min(remaining_beats, MAX_BURST, split limit per REQ-035).
REQ-024 REQ SHALL assert wr_req only when fifo_count >= burst_len; wr_addr/wr_len stable while wr_req high.
REQ-025 REQ->DATA on wr_req & wr_req_ack; wr_req deasserts same edge.
REQ-026 DATA: wr_wvalid = !fifo_empty; wr_wlast high on the burst's final beat only.
REQ-027 DATA->WAIT_B after last beat handshake; bready high only in WAIT_B.
REQ-028 WAIT_B on bresp: addr += burst_len*64, remaining -= burst_len; ->REQ if remaining>0 else ->DONE.
REQ-029 One burst outstanding at a time.
REQ-030 DONE: done=1, busy=0; start re-enters per REQ-022 and clears done same edge.
REQ-031 start while busy SHALL be ignored.
REQ-032 Simultaneous FIFO push and pop SHALL keep count unchanged; full/empty exact at boundaries.
REQ-033 Beats beyond total_beats SHALL not be accepted (in_ready=0 once accepted==total_beats).

Reset
REQ-034 On rst: state IDLE, FIFO emptied, all counters 0; wr_req, wr_wvalid, wr_wlast, bready, busy, done = 0; in_ready = 0; wr_addr, wr_len = 0. Reset mid-burst aborts without further handshakes.

Configuration
REQ-035 With WR_PACKER_4K_SPLIT_EN defined: burst_len also limited to (4096 - addr[11:0])/64, so no burst crosses a 4 KB boundary; without it: only remaining and MAX_BURST limit.

Structure
REQ-036 Package wr_packer_pkg SHALL hold state enum, BEAT_BYTES, PAGE_BYTES=4096, default MAX_BURST.
REQ-037 Sub-module wr_beat_fifo (synchronous FIFO, data+strobe, count output) SHALL implement buffering.

Verification
REQ-038 start, len=0 -> done=1 within 2 cycles, no wr_req.
REQ-039 des_addr=0x1000, len=8192, stream 128 beats -> two requests: addr 0x1000 len 63, 0x2000 len 63; wlast on beats 64,128.
REQ-040 With WR_PACKER_4K_SPLIT_EN, des_addr=0x1F80, len=256 -> requests 0x1F80 len 1, 0x2000 len 1; without macro -> one request 0x1F80 len 3.
REQ-041 len=100 -> one request len 1; second beat strobe forwarded as supplied; done after bresp.
REQ-042 wr_ready toggling 50% and in_valid burst of 64 with FIFO_DEPTH=64 -> in_ready drops at full, no beat lost or duplicated.
REQ-043 rst asserted mid-DATA -> all outputs zero next cycle; fresh start then completes normally.
